// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and the funct3-to-access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    RESP
  } lsu_state_e;

  // Access size in bytes; 0 marks an encoding with no defined width.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_req_check.sv
// Combinational legality check for a load/store request: funct3 legality,
// memory range and natural alignment.
module lsu_req_check
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        size,
  output logic              illegal,
  output logic              out_of_range,
  output logic              misaligned
);

  logic [ADDR_W:0] last_byte;

  always_comb begin
    size = access_size(funct3);

    if (we) illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    else    illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});

    // One extra bit keeps addr + N - 1 from wrapping near the top of the space.
    last_byte    = {1'b0, addr} + (ADDR_W+1)'(size) - (ADDR_W+1)'(size != 3'd0);
    out_of_range = last_byte >= (ADDR_W+1)'(MEM_BYTES);

    case (size)
      3'd2:    misaligned = addr[0];
      3'd4:    misaligned = addr[1:0] != 2'b00;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, checks it, drives the data memory
// port and returns a one-cycle response. LSU_MISALIGNED_SPLIT_EN enables
// splitting misaligned halfword/word accesses into byte accesses.
//
// state  | meaning
// IDLE   | ready for a request; legality decided on accept
// ACCESS | single aligned memory access, load data captured
// SPLIT  | one byte access per cycle for a misaligned request
// RESP   | response pulse, then back to IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        chk_size;
  logic              chk_illegal;
  logic              chk_out_of_range;
  logic              chk_misaligned;
  logic              accept;
  logic              reject;

  lsu_req_check #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_req_check (
    .we           (req_we),
    .funct3       (req_funct3),
    .addr         (req_addr),
    .size         (chk_size),
    .illegal      (chk_illegal),
    .out_of_range (chk_out_of_range),
    .misaligned   (chk_misaligned)
  );

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [2:0]  size_q;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;
  logic [7:0]  wdata_byte;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [31:0] split_rdata;

  assign reject = chk_illegal || chk_out_of_range;

  // Byte k of the assembly is taken from the current byte read; the final
  // extension follows the original halfword funct3.
  always_comb begin
    last_idx   = 2'(size_q - 3'd1);
    wdata_byte = wdata_q[{byte_idx, 3'b000} +: 8];
    asm_next   = asm_q;
    asm_next[{byte_idx, 3'b000} +: 8] = mem_read_data[7:0];
    case (funct3_q)
      F3_LH:   split_rdata = {{16{asm_next[15]}}, asm_next[15:0]};
      F3_LHU:  split_rdata = {16'h0000, asm_next[15:0]};
      default: split_rdata = asm_next;
    endcase
  end
`else
  logic [2:0] size_unused;

  assign size_unused = chk_size;
  assign reject      = chk_illegal || chk_out_of_range || chk_misaligned;
`endif

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_funct3     = '0;
    case (state)
      ACCESS: begin
        mem_read       = !we_q;
        mem_write      = we_q;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_funct3     = funct3_q;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      SPLIT: begin
        mem_read       = !we_q;
        mem_write      = we_q;
        mem_address    = addr_q + ADDR_W'(byte_idx);
        mem_write_data = {24'h000000, wdata_byte};
        mem_funct3     = we_q ? F3_SB : F3_LBU;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      size_q     <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
            size_q   <= chk_size;
`endif
            if (reject) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            else if (chk_misaligned) begin
              byte_idx <= '0;
              asm_q    <= '0;
              state    <= SPLIT;
            end
`endif
            else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= we_q ? 32'h0 : mem_read_data;
          state      <= RESP;
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        SPLIT: begin
          asm_q    <= asm_next;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == last_idx) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'h0 : split_rdata;
            state      <= RESP;
          end
        end
`endif
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
